// File: rtl/counter_2d_seq.sv
// Two-axis raster position counter: start latches limits/axis order, inc steps one position, wraps at (row_max,col_max).
// Position, wrap and done are registered (one edge after the command); inc is a strobe with no backpressure.
module counter_2d_seq #(
  parameter int CW = 10
) (
  input  logic          CLK,
  input  logic          RST_L,
  input  logic          start,
  input  logic          stop,
  input  logic          inc,
  input  logic          col_major,
  input  logic          one_shot,
  input  logic [CW-1:0] row_max,
  input  logic [CW-1:0] col_max,
  output logic          busy,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          first,
  output logic          last,
  output logic          wrap,
  output logic          done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row_max_q;
  logic [CW-1:0] r_col_max_q;
  logic          r_col_major_q;
  logic          r_one_shot_q;
  logic          r_wrap;
  logic          r_done;

  logic [CW-1:0] w_row_nxt;
  logic [CW-1:0] w_col_nxt;
  logic          w_wrap_nxt;
  logic          w_done_nxt;
  logic          w_latch;
  logic          w_row_at_max;
  logic          w_col_at_max;

  assign w_row_at_max = (r_row == r_row_max_q);
  assign w_col_at_max = (r_col == r_col_max_q);

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Priority: stop, then start (restart swallows a coincident inc), then inc.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
    end else if (start) begin
      w_state_nxt = RUN;
      w_latch     = 1'b1;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
    end else if ((r_state == RUN) && inc) begin
      if (w_row_at_max && w_col_at_max) begin
        w_row_nxt  = '0;
        w_col_nxt  = '0;
        w_wrap_nxt = 1'b1;
        if (r_one_shot_q) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end else if (!r_col_major_q) begin
        if (r_col < r_col_max_q) begin
          w_col_nxt = r_col + 1'b1;
        end else begin
          w_col_nxt = '0;
          w_row_nxt = r_row + 1'b1;
        end
      end else begin
        if (r_row < r_row_max_q) begin
          w_row_nxt = r_row + 1'b1;
        end else begin
          w_row_nxt = '0;
          w_col_nxt = r_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      r_row         <= '0;
      r_col         <= '0;
      r_row_max_q   <= '0;
      r_col_max_q   <= '0;
      r_col_major_q <= 1'b0;
      r_one_shot_q  <= 1'b0;
      r_wrap        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_row  <= w_row_nxt;
      r_col  <= w_col_nxt;
      r_wrap <= w_wrap_nxt;
      r_done <= w_done_nxt;
      if (w_latch) begin
        r_row_max_q   <= row_max;
        r_col_max_q   <= col_max;
        r_col_major_q <= col_major;
        r_one_shot_q  <= one_shot;
      end
    end
  end

  assign busy  = (r_state == RUN);
  assign row   = r_row;
  assign col   = r_col;
  assign wrap  = r_wrap;
  assign done  = r_done;
  assign first = busy & (r_row == '0) & (r_col == '0);
  assign last  = busy & w_row_at_max & w_col_at_max;

endmodule

// File: tb/tb_counter_2d_seq.sv
// Bench for counter_2d_seq: directed vector table, hand-written corner sequences and a random run
// checked against a linear-index reference model.
module tb_counter_2d_seq;
  localparam int CW = 10;

  logic          CLK = 1'b0;
  logic          RST_L = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          inc = 1'b0;
  logic          col_major = 1'b0;
  logic          one_shot = 1'b0;
  logic [CW-1:0] row_max = '0;
  logic [CW-1:0] col_max = '0;
  logic          busy, first, last, wrap, done;
  logic [CW-1:0] row, col;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: scan position kept as a linear index into the latched grid.
  bit m_busy, m_wrap, m_done, m_cm, m_os;
  int m_idx, m_rmax, m_cmax;

  counter_2d_seq #(.CW(CW)) dut (
    .CLK(CLK), .RST_L(RST_L), .start(start), .stop(stop), .inc(inc),
    .col_major(col_major), .one_shot(one_shot), .row_max(row_max), .col_max(col_max),
    .busy(busy), .row(row), .col(col), .first(first), .last(last), .wrap(wrap), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic st, sp, ic, cm, os;
    int   rm, cx, er, ec;
    logic eb, ew, ed, ef, el;
  } vec_t;
  vec_t vt[$];

  function automatic void addv(logic st, logic sp, logic ic, logic cm, logic os, int rm, int cx,
                               int er, int ec, logic eb, logic ew, logic ed, logic ef, logic el);
    vec_t v;
    v.st = st; v.sp = sp; v.ic = ic; v.cm = cm; v.os = os; v.rm = rm; v.cx = cx;
    v.er = er; v.ec = ec; v.eb = eb; v.ew = ew; v.ed = ed; v.ef = ef; v.el = el;
    vt.push_back(v);
  endfunction

  function automatic void tinc(logic cm, int er, int ec, logic eb, logic ew, logic ed, logic el);
    addv(1'b0, 1'b0, 1'b1, cm, 1'b1, 2, 3, er, ec, eb, ew, ed, 1'b0, el);
  endfunction

  function automatic int m_row();
    if (!m_busy) return 0;
    return m_cm ? (m_idx % (m_rmax + 1)) : (m_idx / (m_cmax + 1));
  endfunction

  function automatic int m_col();
    if (!m_busy) return 0;
    return m_cm ? (m_idx / (m_rmax + 1)) : (m_idx % (m_cmax + 1));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_wrap = 0; m_done = 0; m_cm = 0; m_os = 0;
    m_idx = 0; m_rmax = 0; m_cmax = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    int r, c;
    r = m_row();
    c = m_col();
    check({tag, ".row"}, 32'(row), r);
    check({tag, ".col"}, 32'(col), c);
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".first"}, 32'(first), 32'(m_busy && r == 0 && c == 0));
    check({tag, ".last"}, 32'(last), 32'(m_busy && r == m_rmax && c == m_cmax));
  endtask

  task automatic step(input logic st, input logic sp, input logic ic, input logic cm,
                      input logic os, input int rm, input int cx, input string tag);
    start = st; stop = sp; inc = ic; col_major = cm; one_shot = os;
    row_max = rm[CW-1:0]; col_max = cx[CW-1:0];
    m_wrap = 0; m_done = 0;
    if (sp) begin
      m_busy = 0; m_idx = 0;
    end else if (st) begin
      m_busy = 1; m_idx = 0; m_rmax = rm; m_cmax = cx; m_cm = cm; m_os = os;
    end else if (m_busy && ic) begin
      m_idx++;
      if (m_idx == (m_rmax + 1) * (m_cmax + 1)) begin
        m_idx = 0; m_wrap = 1;
        if (m_os) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
    @(posedge CLK);
    #1;
    cmp_model(tag);
  endtask

  initial begin
    model_reset();
    #2;
    cmp_model("reset");
    @(posedge CLK); #1;
    RST_L = 1'b1;
    step(0, 0, 1, 0, 0, 3, 3, "idle_inc");

    // Row-major then column-major one-shot scans of a 3x4 grid.
    addv(1, 0, 0, 0, 1, 2, 3, 0, 0, 1, 0, 0, 1, 0);
    tinc(0, 0, 1, 1, 0, 0, 0); tinc(0, 0, 2, 1, 0, 0, 0); tinc(0, 0, 3, 1, 0, 0, 0);
    tinc(0, 1, 0, 1, 0, 0, 0); tinc(0, 1, 1, 1, 0, 0, 0); tinc(0, 1, 2, 1, 0, 0, 0);
    tinc(0, 1, 3, 1, 0, 0, 0); tinc(0, 2, 0, 1, 0, 0, 0); tinc(0, 2, 1, 1, 0, 0, 0);
    tinc(0, 2, 2, 1, 0, 0, 0); tinc(0, 2, 3, 1, 0, 0, 1); tinc(0, 0, 0, 0, 1, 1, 0);
    addv(1, 0, 0, 1, 1, 2, 3, 0, 0, 1, 0, 0, 1, 0);
    tinc(1, 1, 0, 1, 0, 0, 0); tinc(1, 2, 0, 1, 0, 0, 0); tinc(1, 0, 1, 1, 0, 0, 0);
    tinc(1, 1, 1, 1, 0, 0, 0); tinc(1, 2, 1, 1, 0, 0, 0); tinc(1, 0, 2, 1, 0, 0, 0);
    tinc(1, 1, 2, 1, 0, 0, 0); tinc(1, 2, 2, 1, 0, 0, 0); tinc(1, 0, 3, 1, 0, 0, 0);
    tinc(1, 1, 3, 1, 0, 0, 0); tinc(1, 2, 3, 1, 0, 0, 1); tinc(1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].st, vt[i].sp, vt[i].ic, vt[i].cm, vt[i].os, vt[i].rm, vt[i].cx, $sformatf("vec%0d", i));
      check($sformatf("tbl%0d.row", i), 32'(row), vt[i].er);
      check($sformatf("tbl%0d.col", i), 32'(col), vt[i].ec);
      check($sformatf("tbl%0d.busy", i), 32'(busy), 32'(vt[i].eb));
      check($sformatf("tbl%0d.wrap", i), 32'(wrap), 32'(vt[i].ew));
      check($sformatf("tbl%0d.done", i), 32'(done), 32'(vt[i].ed));
      check($sformatf("tbl%0d.first", i), 32'(first), 32'(vt[i].ef));
      check($sformatf("tbl%0d.last", i), 32'(last), 32'(vt[i].el));
    end

    // Continuous 2x2 scan: wraps after incs 4 and 8, never done.
    step(1, 0, 0, 0, 0, 1, 1, "cont_start");
    for (int k = 1; k <= 9; k++) begin
      step(0, 0, 1, 0, 0, 1, 1, "cont");
      check($sformatf("cont%0d.wrap", k), 32'(wrap), 32'(k == 4 || k == 8));
      check($sformatf("cont%0d.done", k), 32'(done), 0);
      check($sformatf("cont%0d.busy", k), 32'(busy), 1);
    end
    check("cont.final_row", 32'(row), 0);
    check("cont.final_col", 32'(col), 1);

    // stop+start together, then start+inc together, both at (1,2).
    step(1, 0, 0, 0, 1, 2, 3, "prio_start");
    for (int k = 0; k < 6; k++) step(0, 0, 1, 0, 1, 2, 3, "prio_inc");
    check("prio.at_row", 32'(row), 1);
    check("prio.at_col", 32'(col), 2);
    step(1, 1, 1, 0, 1, 2, 3, "stop_start");
    check("stop_start.busy", 32'(busy), 0);
    check("stop_start.row", 32'(row), 0);
    check("stop_start.col", 32'(col), 0);
    step(1, 0, 0, 0, 1, 2, 3, "prio_start2");
    for (int k = 0; k < 6; k++) step(0, 0, 1, 0, 1, 2, 3, "prio_inc2");
    step(1, 0, 1, 0, 1, 2, 3, "start_inc");
    check("start_inc.busy", 32'(busy), 1);
    check("start_inc.row", 32'(row), 0);
    check("start_inc.col", 32'(col), 0);
    step(0, 0, 1, 0, 1, 2, 3, "after_restart");
    check("after_restart.col", 32'(col), 1);

    // Limit input changed mid-scan must not stretch the scan.
    step(1, 0, 0, 0, 1, 2, 3, "lim_start");
    for (int k = 1; k <= 12; k++) step(0, 0, 1, 0, 1, (k > 5) ? 5 : 2, 3, "lim_inc");
    check("lim.done", 32'(done), 1);
    check("lim.wrap", 32'(wrap), 1);
    check("lim.busy", 32'(busy), 0);

    // Asynchronous reset mid-scan at (1,1).
    step(1, 0, 0, 0, 1, 2, 3, "rst_start");
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 1, 2, 3, "rst_inc");
    check("rst.pre_row", 32'(row), 1);
    check("rst.pre_col", 32'(col), 1);
    RST_L = 1'b0;
    #1;
    check("rst.row", 32'(row), 0);
    check("rst.col", 32'(col), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.wrap", 32'(wrap), 0);
    check("rst.done", 32'(done), 0);
    model_reset();
    @(posedge CLK); #1;
    cmp_model("rst_hold");
    RST_L = 1'b1;
    step(0, 0, 1, 0, 1, 2, 3, "rst_after");

    // Single-position grid: every inc wraps, first and last stay high.
    step(1, 0, 0, 0, 0, 0, 0, "one_start");
    check("one.first", 32'(first), 1);
    check("one.last", 32'(last), 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 0, 0, 0, "one_inc");
      check($sformatf("one%0d.wrap", k), 32'(wrap), 1);
      check($sformatf("one%0d.first", k), 32'(first), 1);
      check($sformatf("one%0d.last", k), 32'(last), 1);
    end

    // Full-width column limit.
    step(1, 0, 0, 0, 0, 0, 1023, "max_start");
    for (int k = 0; k < 1023; k++) step(0, 0, 1, 0, 0, 0, 1023, "max_inc");
    check("max.col", 32'(col), 1023);
    check("max.last", 32'(last), 1);
    step(0, 0, 1, 0, 0, 0, 1023, "max_wrap");
    check("max.wrap", 32'(wrap), 1);
    check("max.col0", 32'(col), 0);

    // Random commands against the model.
    step(0, 1, 0, 0, 0, 0, 0, "rnd_clear");
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 5, r >= 5 && r < 8, $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_2d_seq.md
COUNTER_2D_SEQ -- requirements
Module: counter_2d_seq

Interface
REQ-001 The block SHALL have parameter CW, default 10, giving the width of the row and column counts and limits.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_L, input, 1, reset: asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, which begins a scan and latches its configuration.
REQ-005 The block SHALL have port stop, input, 1, which aborts a scan and returns the block to idle.
REQ-006 The block SHALL have port inc, input, 1, which advances the count by one position while running.
REQ-007 The block SHALL have port col_major, input, 1: 0 = col is the fast axis; 1 = row is the fast axis.
REQ-008 The block SHALL have port one_shot, input, 1: 1 = stop after one full scan; 0 = wrap and continue.
REQ-009 The block SHALL have port row_max, input, CW, the inclusive row limit.
REQ-010 The block SHALL have port col_max, input, CW, the inclusive column limit.
REQ-011 The block SHALL have port busy, output, 1, which is high while in RUN.
REQ-012 The block SHALL have ports row and col, outputs, CW each, the registered current position.
REQ-013 The block SHALL have ports first and last, outputs, 1 each, which flag the position (0,0) and the position (row_max_q,col_max_q) respectively.
REQ-014 The block SHALL have ports wrap and done, outputs, 1 each, each a registered one-cycle pulse.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-016 In IDLE, the block SHALL hold row = col = 0 and busy = 0, and SHALL ignore inc.
REQ-017 When start = 1, the block SHALL latch row_max, col_max, col_major and one_shot into internal _q copies, load row = col = 0 and enter RUN on the next edge; this applies in both IDLE and RUN (restart).
REQ-018 When stop = 1, the block SHALL enter IDLE on the next edge with row = col = 0, and stop SHALL take priority over start and inc.
REQ-019 When start = 1 and inc = 1 are both asserted in RUN, start SHALL win and the count SHALL NOT advance.
REQ-020 On inc = 1 in RUN with col_major_q = 0: if col < col_max_q, then col SHALL be col+1; otherwise col SHALL be 0 and row SHALL be row+1.
REQ-021 On inc = 1 in RUN with col_major_q = 1, the rule of REQ-020 SHALL apply with the roles of row and col swapped.
REQ-022 On inc = 1 at (row_max_q,col_max_q), the count SHALL return to (0,0) and wrap SHALL pulse high for one cycle, coincident with the new (0,0).
REQ-023 At the wrap of REQ-022 with one_shot_q = 1, the block SHALL also enter IDLE, pulse done for one cycle in the same cycle as wrap, and busy SHALL fall.
REQ-024 At the wrap of REQ-022 with one_shot_q = 0, the block SHALL remain in RUN and done SHALL stay 0.
REQ-025 A limit of 0 SHALL mean an axis of size 1; with row_max = col_max = 0, every inc SHALL produce a wrap.
REQ-026 Counter arithmetic SHALL be CW bits wide with no overflow past the latched limit; a limit of 2^CW-1 SHALL be legal.
REQ-027 Changes to row_max, col_max, col_major or one_shot during RUN SHALL have no effect until the next start.
REQ-028 first SHALL equal busy & (row==0) & (col==0), combinational from registered state.
REQ-029 last SHALL equal busy & (row==row_max_q) & (col==col_max_q), combinational from registered state.
REQ-030 When inc = 0, row and col SHALL hold their values.

Reset
REQ-031 While RST_L = 0, the block SHALL immediately force state = IDLE; row = col = 0; busy = wrap = done = 0; all _q registers to 0.
REQ-032 After RST_L rises, the block SHALL remain in IDLE until a start is sampled.
REQ-033 Reset asserted mid-scan SHALL discard the scan, and no done or wrap pulse SHALL be emitted.

Verification
REQ-034 Bench SHALL cover: CW=10, row_max=2, col_max=3, col_major=0, one_shot=1, start, then 12 incs -> sequence (0,0),(0,1)..(0,3),(1,0)..(2,3); 12th inc gives wrap=done=1 for one cycle, busy=0, (0,0).
REQ-035 Bench SHALL cover: the same settings with col_major=1 -> sequence (0,0),(1,0),(2,0),(0,1)..; last=1 at (2,3).
REQ-036 Bench SHALL cover: one_shot=0, row_max=col_max=1, 9 incs -> wrap pulses after incs 4 and 8, done never set, busy stays 1, final position (0,1).
REQ-037 Bench SHALL cover: stop and start asserted together at (1,2) -> IDLE with (0,0) and busy=0; a start and inc together at (1,2) -> (0,0), busy=1, no advance.
REQ-038 Bench SHALL cover: row_max changed from 2 to 5 mid-scan -> the scan still wraps after row 2; RST_L pulsed low at (1,1) -> outputs 0 immediately and no done pulse.
REQ-039 Bench SHALL cover: row_max=col_max=0 and one_shot=0 -> every inc gives wrap=1 and first=last=1 throughout.
